// File: rtl/regcopy_serializer.sv
// Snapshots the three register-copy words on a capture request and streams
// them out one beat at a time over valid/ready, with an optional XOR checksum beat.
module regcopy_serializer #(
  parameter int W       = 4,
  parameter int ADD_CHK = 1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     Q1,
  input  logic [W-1:0]     Q2,
  input  logic [W-1:0]     Q3,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [W-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sof,
  output logic             out_eof,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             busy
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [1:0] LAST = (ADD_CHK != 0) ? 2'd3 : 2'd2;

  state_t            state;
  logic [1:0]        idx;
  logic [1:0]        nxt;
  logic [3:0][W-1:0] words;   // slot 3 holds the checksum

  assign nxt = idx + 2'd1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      idx       <= 2'd0;
      words     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      busy      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            words[0]  <= Q1;
            words[1]  <= Q2;
            words[2]  <= Q3;
            words[3]  <= Q1 ^ Q2 ^ Q3;
            idx       <= 2'd0;
            state     <= SEND;
            in_ready  <= 1'b0;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            out_data  <= Q1;
            out_sof   <= 1'b1;
            out_eof   <= 1'b0;
          end
        end
        SEND: begin
          // Without out_ready every output register simply holds.
          if (out_ready) begin
            if (idx == LAST) begin
              frame_cnt <= frame_cnt + CNT_W'(1);
              state     <= IDLE;
              idx       <= 2'd0;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              out_data  <= '0;
              out_sof   <= 1'b0;
              out_eof   <= 1'b0;
            end else begin
              idx      <= nxt;
              out_data <= words[nxt];
              out_sof  <= 1'b0;
              out_eof  <= (nxt == LAST);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regcopy_serializer.sv
// Bench for regcopy_serializer: directed frames, backpressure, back-to-back,
// counter wrap, mid-frame reset and randomized frames against a beat-list model.
module tb_regcopy_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] q1, q2, q3;
  logic       in_valid, out_ready;

  logic       in_ready, out_valid, out_sof, out_eof, busy;
  logic [3:0] out_data;
  logic [7:0] frame_cnt;

  logic       nc_in_ready, nc_out_valid, nc_out_sof, nc_out_eof, nc_busy;
  logic [3:0] nc_out_data;
  logic [7:0] nc_frame_cnt;

  logic       c2_in_ready, c2_out_valid, c2_out_sof, c2_out_eof, c2_busy;
  logic [3:0] c2_out_data;
  logic [1:0] c2_frame_cnt;

  int n_chk = 0;
  int n_fail = 0;

  logic [5:0] obs[$], nc_obs[$];
  logic [5:0] exp_q[$], nc_exp_q[$];

  always #5 clk = ~clk;

  regcopy_serializer dut (
    .clk(clk), .rst(rst), .Q1(q1), .Q2(q2), .Q3(q3), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_sof(out_sof), .out_eof(out_eof),
    .frame_cnt(frame_cnt), .busy(busy));

  regcopy_serializer #(.ADD_CHK(0)) dut_nc (
    .clk(clk), .rst(rst), .Q1(q1), .Q2(q2), .Q3(q3), .in_valid(in_valid),
    .in_ready(nc_in_ready), .out_data(nc_out_data), .out_valid(nc_out_valid),
    .out_ready(out_ready), .out_sof(nc_out_sof), .out_eof(nc_out_eof),
    .frame_cnt(nc_frame_cnt), .busy(nc_busy));

  regcopy_serializer #(.CNT_W(2)) dut_c2 (
    .clk(clk), .rst(rst), .Q1(q1), .Q2(q2), .Q3(q3), .in_valid(in_valid),
    .in_ready(c2_in_ready), .out_data(c2_out_data), .out_valid(c2_out_valid),
    .out_ready(out_ready), .out_sof(c2_out_sof), .out_eof(c2_out_eof),
    .frame_cnt(c2_frame_cnt), .busy(c2_busy));

  // Record every accepted beat as {sof, eof, data}.
  always @(negedge clk) begin
    if (rst) begin
      if (out_valid && out_ready) obs.push_back({out_sof, out_eof, out_data});
      if (nc_out_valid && out_ready) nc_obs.push_back({nc_out_sof, nc_out_eof, nc_out_data});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_all();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    q1 = 4'h0; q2 = 4'h0; q3 = 4'h0;
    tick(); tick();
    rst = 1'b1;
    obs.delete(); nc_obs.delete(); exp_q.delete(); nc_exp_q.delete();
  endtask

  function automatic void model_frame(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    exp_q.push_back({2'b10, a});
    exp_q.push_back({2'b00, b});
    exp_q.push_back({2'b00, c});
    exp_q.push_back({2'b01, a ^ b ^ c});
    nc_exp_q.push_back({2'b10, a});
    nc_exp_q.push_back({2'b00, b});
    nc_exp_q.push_back({2'b01, c});
  endfunction

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    q1 = 4'h7; q2 = 4'h1; q3 = 4'h2;
    tick(); tick();
    n_chk++;
    if ({in_ready, out_valid, out_data, out_sof, out_eof, busy, frame_cnt} !== {1'b1, 1'b0, 4'h0, 3'b000, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b vld=%b data=%h sof=%b eof=%b busy=%b cnt=%0d want rdy=1 others 0",
               in_ready, out_valid, out_data, out_sof, out_eof, busy, frame_cnt);
    end
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  // Directed frame A,5,3 with the inputs overwritten right after capture.
  task automatic test_basic();
    logic [3:0] e[4];
    reset_all();
    e[0] = 4'hA; e[1] = 4'h5; e[2] = 4'h3; e[3] = 4'hA ^ 4'h5 ^ 4'h3;
    q1 = e[0]; q2 = e[1]; q3 = e[2]; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; q1 = 4'hF; q2 = 4'hF; q3 = 4'hF;
    for (int b = 0; b < 4; b++) begin
      n_chk++;
      if ({out_valid, busy, in_ready, out_sof, out_eof, out_data} !== {3'b110, b == 0, b == 3, e[b]}) begin
        n_fail++;
        $display("FAIL basic_beat%0d: got vld=%b busy=%b rdy=%b sof=%b eof=%b data=%h want data=%h",
                 b, out_valid, busy, in_ready, out_sof, out_eof, out_data, e[b]);
      end
      if (b < 3) begin
        n_chk++;
        if ({nc_out_valid, nc_out_sof, nc_out_eof, nc_out_data} !== {1'b1, b == 0, b == 2, e[b]}) begin
          n_fail++;
          $display("FAIL nochk_same_beat%0d: got vld=%b sof=%b eof=%b data=%h want data=%h",
                   b, nc_out_valid, nc_out_sof, nc_out_eof, nc_out_data, e[b]);
        end
      end
      tick();
    end
    n_chk++;
    if ({in_ready, out_valid, busy, out_data, frame_cnt} !== {3'b100, 4'h0, 8'd1}) begin
      n_fail++;
      $display("FAIL basic_end: got rdy=%b vld=%b busy=%b data=%h cnt=%0d want rdy=1 vld=0 cnt=1",
               in_ready, out_valid, busy, out_data, frame_cnt);
    end
  endtask

  task automatic test_no_chk();
    logic [3:0] e[3];
    reset_all();
    e[0] = 4'h1; e[1] = 4'h2; e[2] = 4'h4;
    q1 = e[0]; q2 = e[1]; q3 = e[2]; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int b = 0; b < 3; b++) begin
      n_chk++;
      if ({nc_out_valid, nc_out_sof, nc_out_eof, nc_out_data} !== {1'b1, b == 0, b == 2, e[b]}) begin
        n_fail++;
        $display("FAIL nochk_beat%0d: got vld=%b sof=%b eof=%b data=%h want data=%h",
                 b, nc_out_valid, nc_out_sof, nc_out_eof, nc_out_data, e[b]);
      end
      tick();
    end
    n_chk++;
    if ({nc_in_ready, nc_out_valid, nc_frame_cnt} !== {2'b10, 8'd1}) begin
      n_fail++;
      $display("FAIL nochk_end: got rdy=%b vld=%b cnt=%0d want rdy=1 vld=0 cnt=1",
               nc_in_ready, nc_out_valid, nc_frame_cnt);
    end
  endtask

  task automatic test_backpressure();
    reset_all();
    q1 = 4'hA; q2 = 4'h5; q3 = 4'h3; in_valid = 1'b1; out_ready = 1'b1;
    model_frame(4'hA, 4'h5, 4'h3);
    tick();
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if ({out_valid, out_sof, out_eof, out_data} !== {3'b100, 4'h5}) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got vld=%b sof=%b eof=%b data=%h want vld=1 sof=0 eof=0 data=5",
                 i, out_valid, out_sof, out_eof, out_data);
      end
      if (i < 3) tick();
    end
    out_ready = 1'b1;
    tick(); tick(); tick();
    n_chk++;
    if (obs.size() != 4 || obs != exp_q) begin
      n_fail++;
      $display("FAIL bp_sequence: got %0d beats %p want %p", obs.size(), obs, exp_q);
    end
    n_chk++;
    if ({in_ready, frame_cnt} !== {1'b1, 8'd1}) begin
      n_fail++;
      $display("FAIL bp_end: got rdy=%b cnt=%0d want rdy=1 cnt=1", in_ready, frame_cnt);
    end
  endtask

  task automatic test_back_to_back();
    reset_all();
    q1 = 4'h9; q2 = 4'h6; q3 = 4'hC; in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      tick();
      if (c == 25) begin
        n_chk++;
        if ({frame_cnt, c2_frame_cnt} !== {8'd5, 2'd1}) begin
          n_fail++;
          $display("FAIL b2b_wrap: got cnt=%0d cnt2=%0d want 5 and 1", frame_cnt, c2_frame_cnt);
        end
      end
    end
    in_valid = 1'b0;
    n_chk++;
    if ({frame_cnt, nc_frame_cnt} !== {8'd10, 8'd12}) begin
      n_fail++;
      $display("FAIL b2b_count: got cnt=%0d nc_cnt=%0d want 10 and 12", frame_cnt, nc_frame_cnt);
    end
    for (int f = 0; f < 10; f++) model_frame(4'h9, 4'h6, 4'hC);
    n_chk++;
    if (obs != exp_q) begin
      n_fail++;
      $display("FAIL b2b_beats: got %0d beats want %0d", obs.size(), exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    reset_all();
    q1 = 4'hA; q2 = 4'h5; q3 = 4'h3; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    out_ready = 1'b0;
    n_chk++;
    if ({out_valid, out_data, frame_cnt} !== {1'b1, 4'h3, 8'd1}) begin
      n_fail++;
      $display("FAIL mid_pre: got vld=%b data=%h cnt=%0d want vld=1 data=3 cnt=1", out_valid, out_data, frame_cnt);
    end
    rst = 1'b0;
    tick();
    n_chk++;
    if ({out_valid, in_ready, out_eof, busy, frame_cnt} !== {4'b0100, 8'd0}) begin
      n_fail++;
      $display("FAIL mid_reset: got vld=%b rdy=%b eof=%b busy=%b cnt=%0d want rdy=1 others 0",
               out_valid, in_ready, out_eof, busy, frame_cnt);
    end
    rst = 1'b1; q1 = 4'h4; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_chk++;
    if ({out_valid, out_sof, out_eof, out_data} !== {3'b110, 4'h4}) begin
      n_fail++;
      $display("FAIL mid_restart: got vld=%b sof=%b eof=%b data=%h want vld=1 sof=1 data=4",
               out_valid, out_sof, out_eof, out_data);
    end
  endtask

  // Random frames, random backpressure and input churn while a frame is in flight.
  task automatic test_random();
    int budget;
    int nframes;
    reset_all();
    nframes = 0;
    for (int f = 0; f < 12; f++) begin
      repeat ($urandom_range(0, 2)) tick();
      q1 = 4'($urandom); q2 = 4'($urandom); q3 = 4'($urandom);
      model_frame(q1, q2, q3);
      in_valid = 1'b1;
      out_ready = 1'($urandom);
      tick();
      in_valid = 1'b0;
      nframes++;
      budget = 0;
      while (!in_ready && budget < 200) begin
        q1 = 4'($urandom); q2 = 4'($urandom); q3 = 4'($urandom);
        out_ready = ($urandom_range(0, 2) != 0);
        tick();
        budget++;
      end
      if (budget >= 200) begin
        n_chk++; n_fail++;
        $display("FAIL rand_timeout: frame %0d never completed", f);
        break;
      end
    end
    out_ready = 1'b1;
    repeat (6) tick();
    n_chk++;
    if (obs != exp_q) begin
      n_fail++;
      $display("FAIL rand_beats: got %0d beats want %0d", obs.size(), exp_q.size());
    end
    n_chk++;
    if (nc_obs != nc_exp_q) begin
      n_fail++;
      $display("FAIL rand_nochk_beats: got %0d beats want %0d", nc_obs.size(), nc_exp_q.size());
    end
    n_chk++;
    if ({frame_cnt, nc_frame_cnt} !== {8'(nframes), 8'(nframes)}) begin
      n_fail++;
      $display("FAIL rand_count: got cnt=%0d nc_cnt=%0d want %0d", frame_cnt, nc_frame_cnt, nframes);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_no_chk();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regcopy_serializer.md
Name: regcopy_serializer

Overview:
- Downstream consumer of the three 4-bit register banks (Q1/Q2/Q3) produced by the register-copy block.
- On a capture request, snapshots all three words in the same clock and streams them out one word per beat over a valid/ready channel, optionally followed by an XOR checksum beat.
- Used as the single narrow test/observation port for the register-copy stage in DCDR benches and scan-style readout.

Parameters:
- W, 4, width of each input word and of out_data
- ADD_CHK, 1, 1 = append checksum beat (Q1^Q2^Q3), giving 4 beats per frame; 0 = 3 beats per frame
- CNT_W, 8, width of the completed-frame counter

Ports:
- clk  input  1  system clock; all state changes on its rising edge
- rst  input  1  synchronous, active-low reset (rst=0 resets on the next rising clk edge)
- Q1  input  W  word 0 of the frame
- Q2  input  W  word 1 of the frame
- Q3  input  W  word 2 of the frame
- in_valid  input  1  capture request
- in_ready  output  1  block can accept a capture; registered
- out_data  output  W  current beat data
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts the beat
- out_sof  output  1  high with the first beat of a frame
- out_eof  output  1  high with the last beat of a frame
- frame_cnt  output  CNT_W  number of completed frames, modulo 2^CNT_W
- busy  output  1  frame in progress (state SEND)

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE, in_ready=1, out_valid=0, out_data=0, out_sof=0, out_eof=0, busy=0, frame_cnt=0, beat index=0, capture buffer=0. While rst=0, in_valid and out_ready are ignored.
- FSM has two states, IDLE and SEND.
- IDLE: in_ready=1, out_valid=0, out_data=0. On in_valid=1 at a clk edge:
  - latch buf0=Q1, buf1=Q2, buf2=Q3 and chk=Q1^Q2^Q3 in that same edge;
  - set idx=0, go to SEND, in_ready=0;
  - out_valid=1 and out_data=buf0 with out_sof=1 are visible in the next cycle. Capture-to-first-beat latency is 1 cycle.
- SEND: out_valid=1, busy=1, in_ready=0.
  - out_data = buf[idx], with idx 0..2 selecting buf0..buf2 and idx 3 selecting chk.
  - out_sof = (idx==0). out_eof = (idx==LAST), where LAST = 3 if ADD_CHK else 2.
- Beat transfer occurs when out_valid=1 and out_ready=1 at a clk edge.
  - If idx<LAST: idx increments.
  - If idx==LAST: frame_cnt increments (wraps 2^CNT_W-1 -> 0), state returns to IDLE, out_valid=0 and in_ready=1 next cycle.
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_sof, out_eof and idx hold unchanged for any number of cycles.
- Q1/Q2/Q3 changes after the capture edge have no effect on the frame in flight.
- in_valid in SEND is ignored; no queuing. An upstream requester must hold in_valid until it sees in_ready.
- Maximum throughput is one frame per LAST+2 cycles (the IDLE capture cycle plus LAST+1 beats).
- Reset mid-frame: the frame is discarded with no eof and no frame_cnt increment; all outputs take reset values on that edge.
- Single-word checksum is a plain bitwise XOR, W bits, with no carry.
- All outputs are registered; there is no combinational path from in_valid or out_ready to any output.

Test Plan:
- Reset release, then Q1=A, Q2=5, Q3=3, in_valid pulsed for 1 cycle, out_ready=1 -> beats A(sof), 5, 3, C(eof) on 4 consecutive cycles starting 1 cycle after capture; frame_cnt=1; in_ready=1 in the following cycle.
- Same stimulus with out_ready=0 for 3 cycles during the beat 5 -> out_data=5 held with sof=0 and eof=0; sequence completes A,5,3,C; no beat duplicated or dropped.
- Q1..Q3 changed to F,F,F one cycle after capture -> frame still A,5,3,C.
- ADD_CHK=0, Q1=1, Q2=2, Q3=4 -> beats 1(sof), 2, 4(eof); frame_cnt=1.
- in_valid held high continuously with out_ready=1 for 10 frames -> new frame every 5 cycles; frame_cnt=10. With CNT_W=2 and 5 frames, frame_cnt wraps to 1.
- rst=0 asserted while beat 3 is pending -> next cycle out_valid=0, frame_cnt=0, in_ready=1; the next capture starts with sof.
